// File: rtl/pdu_pkg.sv
// Shared PDU debug definitions: CPU run-control FSM state encodings and default widths.
package pdu_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned CYC_W   = 32;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_STEP_HI = 3'd1;
    localparam logic [STATE_W-1:0] S_STEP_LO = 3'd2;
    localparam logic [STATE_W-1:0] S_RUN_HI  = 3'd3;
    localparam logic [STATE_W-1:0] S_RUN_LO  = 3'd4;
    localparam logic [STATE_W-1:0] S_HALT    = 3'd5;

    // States in which clk_cpu is driven high
    function automatic logic is_hi_state(input logic [STATE_W-1:0] s);
        return (s == S_STEP_HI) || (s == S_RUN_HI);
    endfunction

    // States in which CPU cycles are being issued
    function automatic logic is_busy_state(input logic [STATE_W-1:0] s);
        return (s == S_STEP_HI) || (s == S_STEP_LO) ||
               (s == S_RUN_HI)  || (s == S_RUN_LO);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sync_edge.sv
// sync_edge: 2-flop synchronizer for a raw board input plus a one-clk rising-edge pulse.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise_c
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_rise_c = r_sync & ~r_sync_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU clock sequencer for the PDU (single step, N-cycle burst, free run, PC breakpoint).
// Optional macro CPU_RUN_CYC_CNT_EN enables the 32-bit issued-cycle counter on cyc_cnt.
module cpu_run_ctrl #(
    parameter int unsigned BURST_W = 8,
    parameter int unsigned PC_W    = pdu_pkg::PC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         step,
    input  logic [BURST_W-1:0]           burst_n,
    input  logic                         bp_en,
    input  logic [PC_W-1:0]              bp_addr,
    input  logic [PC_W-1:0]              pc,
    output logic                         clk_cpu,
    output logic                         halted,
    output logic                         busy,
    output logic [pdu_pkg::STATE_W-1:0]  state,
    output logic [pdu_pkg::CYC_W-1:0]    cyc_cnt
);

    import pdu_pkg::*;

    logic                 r_run_meta;
    logic                 r_run_s;
    logic                 r_run_s_d;
    logic                 w_run_fall;
    logic                 w_step_edge;
    logic                 w_bp_hit;

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [BURST_W-1:0]   r_cnt;
    logic [BURST_W-1:0]   w_cnt_nxt;

    logic                 r_clk_cpu;
    logic                 r_halted;
    logic                 r_busy;

    sync_edge u_step_sync (
        .clk      (clk),
        .rst      (rst),
        .i_async  (step),
        .o_rise_c (w_step_edge)
    );

    // run only needs its level; the extra flop gives the 1->0 transition used to leave HALT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_run_s_d  <= 1'b0;
        end else begin
            r_run_meta <= run;
            r_run_s    <= r_run_meta;
            r_run_s_d  <= r_run_s;
        end
    end

    assign w_run_fall = r_run_s_d & ~r_run_s;
    assign w_bp_hit   = bp_en && (pc == bp_addr);

    // Next state and burst count; breakpoint compare happens only in *_LO on the just-fetched PC
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_run_s) begin
                    w_state_nxt = S_RUN_HI;
                end else if (w_step_edge) begin
                    w_state_nxt = S_STEP_HI;
                    w_cnt_nxt   = (burst_n == '0) ? BURST_W'(1) : burst_n;
                end
            end
            S_STEP_HI: begin
                w_state_nxt = S_STEP_LO;
                w_cnt_nxt   = r_cnt - BURST_W'(1);
            end
            S_STEP_LO: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bp_hit) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_STEP_HI;
                end
            end
            S_RUN_HI: begin
                w_state_nxt = S_RUN_LO;
            end
            S_RUN_LO: begin
                if (w_bp_hit) begin
                    w_state_nxt = S_HALT;
                end else if (!r_run_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN_HI;
                end
            end
            S_HALT: begin
                if (w_step_edge || w_run_fall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they stay aligned with r_state and glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_clk_cpu <= 1'b0;
            r_halted  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_cpu <= is_hi_state(w_state_nxt);
            r_halted  <= (w_state_nxt == S_HALT);
            r_busy    <= is_busy_state(w_state_nxt);
        end
    end

`ifdef CPU_RUN_CYC_CNT_EN
    logic [CYC_W-1:0] r_cyc_cnt;

    // *_HI never loops on itself, so a HI next state is always an entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt <= '0;
        end else if (is_hi_state(w_state_nxt)) begin
            r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
        end
    end

    assign cyc_cnt = r_cyc_cnt;
`else
    assign cyc_cnt = '0;
`endif

    assign clk_cpu = r_clk_cpu;
    assign halted  = r_halted;
    assign busy    = r_busy;
    assign state   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl: step, burst, free run, breakpoint halt/exit, reset in RUN_HI.
module tb_cpu_run_ctrl;

    localparam int unsigned BURST_W = 8;
    localparam int unsigned PC_W    = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               step;
    logic [BURST_W-1:0] burst_n;
    logic               bp_en;
    logic [PC_W-1:0]    bp_addr;
    logic [PC_W-1:0]    pc;
    logic               clk_cpu;
    logic               halted;
    logic               busy;
    logic [2:0]         state;
    logic [31:0]        cyc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int   pulse_cnt = 0;
    int   busy_cnt  = 0;
    int   dbl_hi    = 0;
    logic prev_hi   = 1'b0;
    logic pc_auto   = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .BURST_W (BURST_W),
        .PC_W    (PC_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .step    (step),
        .burst_n (burst_n),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .pc      (pc),
        .clk_cpu (clk_cpu),
        .halted  (halted),
        .busy    (busy),
        .state   (state),
        .cyc_cnt (cyc_cnt)
    );

    // Output monitor, sampled just after each active edge
    always begin
        @(posedge clk);
        #1;
        if (clk_cpu) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_hi) dbl_hi = dbl_hi + 1;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        prev_hi = clk_cpu;
    end

    // Simple CPU fetch model: PC advances by 4 on each clk_cpu rising edge
    always @(posedge clk_cpu) begin
        if (pc_auto) pc = pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cyc(input int n);
`ifdef CPU_RUN_CYC_CNT_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        pulse_cnt = 0;
        busy_cnt  = 0;
        dbl_hi    = 0;
    endtask

    task automatic press();
        step = 1'b1;
        tick(3);
        step = 1'b0;
    endtask

    initial begin : main
        logic found;
        rst     = 1'b1;
        run     = 1'b0;
        step    = 1'b0;
        burst_n = '0;
        bp_en   = 1'b0;
        bp_addr = '0;
        pc      = '0;
        tick(3);
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_clk_cpu", 32'(clk_cpu), 32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_cyc",     cyc_cnt,      exp_cyc(0));
        rst = 1'b0;
        tick(2);

        // Single step, burst_n = 0
        clr();
        burst_n = 8'd0;
        press();
        tick(9);
        chk("step_pulses", 32'(pulse_cnt), 32'd1);
        chk("step_busy",   32'(busy_cnt),  32'd2);
        chk("step_state",  32'(state),     32'd0);
        chk("step_cyc",    cyc_cnt,        exp_cyc(1));

        // Burst of 5, second press mid-burst and burst_n change are ignored
        clr();
        burst_n = 8'd5;
        press();
        tick(3);
        burst_n = 8'd2;
        press();
        tick(20);
        chk("burst5_pulses", 32'(pulse_cnt), 32'd5);
        chk("burst5_busy",   32'(busy_cnt),  32'd10);
        chk("burst5_dbl",    32'(dbl_hi),    32'd0);
        chk("burst5_state",  32'(state),     32'd0);
        chk("burst5_cyc",    cyc_cnt,        exp_cyc(6));

        // Maximum burst length
        clr();
        burst_n = 8'hFF;
        press();
        tick(520);
        chk("burst255_pulses", 32'(pulse_cnt), 32'd255);
        chk("burst255_busy",   32'(busy_cnt),  32'd510);
        chk("burst255_dbl",    32'(dbl_hi),    32'd0);

        // burst_n = 1 behaves as a single step
        clr();
        burst_n = 8'd1;
        press();
        tick(9);
        chk("burst1_pulses", 32'(pulse_cnt), 32'd1);
        chk("burst1_cyc",    cyc_cnt,        exp_cyc(262));

        // Free run for 40 clk, then stop after the in-flight cycle
        clr();
        run = 1'b1;
        tick(40);
        chk("run_pulses40", 32'(pulse_cnt), 32'd19);
        chk("run_dbl",      32'(dbl_hi),    32'd0);
        chk("run_busy",     32'(busy),      32'd1);
        run = 1'b0;
        tick(10);
        chk("run_stop_pulses",  32'(pulse_cnt), 32'd20);
        chk("run_stop_state",   32'(state),     32'd0);
        chk("run_stop_clk_cpu", 32'(clk_cpu),   32'd0);
        chk("run_stop_cyc",     cyc_cnt,        exp_cyc(282));

        // Run to breakpoint at 0x10 with PC stepping by 4 from 0
        clr();
        pc      = '0;
        pc_auto = 1'b1;
        bp_addr = 32'h0000_0010;
        bp_en   = 1'b1;
        run     = 1'b1;
        tick(40);
        chk("bp_pulses",  32'(pulse_cnt), 32'd4);
        chk("bp_halted",  32'(halted),    32'd1);
        chk("bp_state",   32'(state),     32'd5);
        chk("bp_clk_cpu", 32'(clk_cpu),   32'd0);
        chk("bp_busy",    32'(busy),      32'd0);
        chk("bp_pc",      pc,             32'h0000_0010);
        chk("bp_cyc",     cyc_cnt,        exp_cyc(286));

        // run falling exits HALT
        run = 1'b0;
        tick(5);
        chk("halt_runfall_state",  32'(state),     32'd0);
        chk("halt_runfall_halted", 32'(halted),    32'd0);
        chk("halt_runfall_pulses", 32'(pulse_cnt), 32'd4);

        // Breakpoint during a burst, then a step press exits HALT without a pulse
        clr();
        pc      = '0;
        bp_addr = 32'h0000_0008;
        burst_n = 8'd10;
        press();
        tick(15);
        chk("bhalt_pulses", 32'(pulse_cnt), 32'd2);
        chk("bhalt_state",  32'(state),     32'd5);
        chk("bhalt_halted", 32'(halted),    32'd1);
        chk("bhalt_cyc",    cyc_cnt,        exp_cyc(288));
        clr();
        press();
        tick(5);
        chk("bhalt_step_state",  32'(state),     32'd0);
        chk("bhalt_step_halted", 32'(halted),    32'd0);
        chk("bhalt_step_pulses", 32'(pulse_cnt), 32'd0);

        // Resume run with breakpoint disabled
        clr();
        bp_en = 1'b0;
        run   = 1'b1;
        tick(10);
        chk("resume_busy",    32'(busy),             32'd1);
        chk("resume_running", 32'(pulse_cnt != 0),   32'd1);
        run = 1'b0;
        tick(8);
        chk("resume_stop_state", 32'(state), 32'd0);

        // Reset asserted while in RUN_HI
        run   = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (clk_cpu) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstrun_found_hi", 32'(found), 32'd1);
        chk("rstrun_pre_state", 32'(state), 32'd3);
        rst = 1'b1;
        run = 1'b0;
        tick(1);
        chk("rstrun_clk_cpu", 32'(clk_cpu), 32'd0);
        chk("rstrun_state",   32'(state),   32'd0);
        chk("rstrun_halted",  32'(halted),  32'd0);
        chk("rstrun_busy",    32'(busy),    32'd0);
        chk("rstrun_cyc",     cyc_cnt,      32'd0);
        rst = 1'b0;
        tick(5);
        chk("rstrun_idle_after", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
